// File: rtl/kyber_pkg.sv
// Shared definitions for the Kyber sampling datapath.
// Holds the polynomial geometry used by the CBD sampler sequencer, the
// derived counter widths, the sequencer state encoding and the command
// legality check.
package kyber_pkg;

  localparam int N             = 256;
  localparam int ETA           = 2;
  localparam int COEF_PER_WORD = 32 / (2 * ETA);
  localparam int KMAX          = 4;
  localparam int IN_PER_POLY   = N / (2 * COEF_PER_WORD);
  localparam int OUT_PER_POLY  = N / 2;

  // Counter widths sized to hold IN_PER_POLY*KMAX and OUT_PER_POLY*KMAX inclusive.
  localparam int NPOLY_W   = 3;
  localparam int IN_CNT_W  = 7;
  localparam int OUT_CNT_W = 10;
  localparam int ADDR_W    = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  // A command must request between one and KMAX polynomials.
  function automatic logic n_poly_legal(input logic [NPOLY_W-1:0] n);
    return (n >= 3'd1) && (n <= 3'(KMAX));
  endfunction

endpackage

// File: rtl/cbd_seq.sv
// Sequencer for the dual-lane CBD sampler (eta=2).
// Accepts a command for 1..KMAX polynomials, moves 32-bit word pairs from the
// upstream XOF buffer through a one-entry buffer into the cbd block, and
// writes the returned coefficient pairs to polynomial RAM at sequential
// addresses {poly_idx, pair_idx}.
//
// Ports:
//   clk, reset              clock (rising edge), asynchronous active-low reset
//   start, n_poly, abort    command strobe, polynomial count, cancel
//   busy, done, err         status: busy, end-of-command pulse, bad-count pulse
//   src_valid/ready/data_*  upstream word-pair handshake
//   cbd_set                 cbd enable
//   cbd_din_*, cbd_readin,  input pair to cbd
//   cbd_ok_in
//   cbd_dout_*, cbd_ok_out, coefficient pair from cbd
//   cbd_readout
//   mem_we, mem_addr,       polynomial RAM write port
//   mem_wdata_*
module cbd_seq
  import kyber_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NPOLY_W-1:0]  n_poly,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [31:0]         src_data_1,
  input  logic [31:0]         src_data_2,
  output logic                cbd_set,
  output logic [31:0]         cbd_din_1,
  output logic [31:0]         cbd_din_2,
  output logic                cbd_readin,
  input  logic                cbd_ok_in,
  input  logic [15:0]         cbd_dout_1,
  input  logic [15:0]         cbd_dout_2,
  input  logic                cbd_ok_out,
  output logic                cbd_readout,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [15:0]         mem_wdata_1,
  output logic [15:0]         mem_wdata_2
);

  seq_state_t            state_r, state_next_s;
  logic [IN_CNT_W-1:0]   total_in_r, in_cnt_r;
  logic [OUT_CNT_W-1:0]  total_out_r, out_cnt_r;
  logic                  in_buf_valid_r;
  logic [31:0]           in_buf_1_r, in_buf_2_r;
  logic                  mem_we_r;
  logic [ADDR_W-1:0]     mem_addr_r;
  logic [15:0]           mem_wdata_1_r, mem_wdata_2_r;
  logic                  err_r, cbd_set_r;

  logic run_s, start_ok_s, stay_run_s;
  logic src_ready_s, cbd_readout_s;
  logic src_fire_s, cbd_in_fire_s, cbd_out_fire_s;

  assign run_s          = (state_r == ST_RUN);
  assign start_ok_s     = start && n_poly_legal(n_poly);
  assign stay_run_s     = (state_next_s == ST_RUN);
  assign src_ready_s    = run_s && !in_buf_valid_r && (in_cnt_r < total_in_r);
  assign cbd_readout_s  = run_s && (out_cnt_r < total_out_r);
  assign src_fire_s     = src_valid && src_ready_s;
  assign cbd_in_fire_s  = in_buf_valid_r && cbd_ok_in;
  assign cbd_out_fire_s = cbd_readout_s && cbd_ok_out;

  // Next-state decode. out_cnt reaches total_out on the same edge that
  // registers the final write, so RUN leaves while that write is on the port.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_next_s = ST_ARM;
        else            state_next_s = ST_IDLE;
      end
      ST_ARM: begin
        if (abort) state_next_s = ST_IDLE;
        else       state_next_s = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                          state_next_s = ST_IDLE;
        else if (out_cnt_r == total_out_r)  state_next_s = ST_DONE;
        else                                state_next_s = ST_RUN;
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Command totals, latched when a legal start is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_in_r  <= '0;
      total_out_r <= '0;
    end else if ((state_r == ST_IDLE) && start_ok_s) begin
      total_in_r  <= IN_CNT_W'(n_poly) * IN_CNT_W'(IN_PER_POLY);
      total_out_r <= OUT_CNT_W'(n_poly) * OUT_CNT_W'(OUT_PER_POLY);
    end else begin
      total_in_r  <= total_in_r;
      total_out_r <= total_out_r;
    end
  end

  // Transfer counters; cleared whenever the sequencer leaves RUN (abort or finish).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cnt_r  <= '0;
      out_cnt_r <= '0;
    end else if (!stay_run_s) begin
      in_cnt_r  <= '0;
      out_cnt_r <= '0;
    end else begin
      in_cnt_r  <= src_fire_s     ? in_cnt_r + 7'd1   : in_cnt_r;
      out_cnt_r <= cbd_out_fire_s ? out_cnt_r + 10'd1 : out_cnt_r;
    end
  end

  // One-entry input buffer between upstream and cbd. Fill and drain never
  // coincide because src_ready requires the buffer to be empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_buf_valid_r <= 1'b0;
      in_buf_1_r     <= '0;
      in_buf_2_r     <= '0;
    end else begin
      if (!stay_run_s)        in_buf_valid_r <= 1'b0;
      else if (src_fire_s)    in_buf_valid_r <= 1'b1;
      else if (cbd_in_fire_s) in_buf_valid_r <= 1'b0;
      else                    in_buf_valid_r <= in_buf_valid_r;
      if (src_fire_s) begin
        in_buf_1_r <= src_data_1;
        in_buf_2_r <= src_data_2;
      end else begin
        in_buf_1_r <= in_buf_1_r;
        in_buf_2_r <= in_buf_2_r;
      end
    end
  end

  // RAM write port: one cycle after each consumed cbd pair. A pair consumed
  // on the abort edge is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we_r      <= 1'b0;
      mem_addr_r    <= '0;
      mem_wdata_1_r <= '0;
      mem_wdata_2_r <= '0;
    end else begin
      mem_we_r <= cbd_out_fire_s && stay_run_s;
      if (cbd_out_fire_s) begin
        mem_addr_r    <= out_cnt_r[ADDR_W-1:0];
        mem_wdata_1_r <= cbd_dout_1;
        mem_wdata_2_r <= cbd_dout_2;
      end else begin
        mem_addr_r    <= mem_addr_r;
        mem_wdata_1_r <= mem_wdata_1_r;
        mem_wdata_2_r <= mem_wdata_2_r;
      end
    end
  end

  // Error pulse and cbd enable; cbd_set is high through RUN and DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r     <= 1'b0;
      cbd_set_r <= 1'b0;
    end else begin
      err_r     <= (state_r == ST_IDLE) && start && !n_poly_legal(n_poly);
      cbd_set_r <= (state_next_s == ST_RUN) || (state_next_s == ST_DONE);
    end
  end

  assign busy        = (state_r != ST_IDLE);
  assign done        = (state_r == ST_DONE);
  assign err         = err_r;
  assign src_ready   = src_ready_s;
  assign cbd_set     = cbd_set_r;
  assign cbd_din_1   = in_buf_1_r;
  assign cbd_din_2   = in_buf_2_r;
  assign cbd_readin  = in_buf_valid_r;
  assign cbd_readout = cbd_readout_s;
  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata_1 = mem_wdata_1_r;
  assign mem_wdata_2 = mem_wdata_2_r;

endmodule

// File: tb/tb_cbd_seq.sv
// Bench for cbd_seq. An upstream source and a cbd model run in one process
// on the falling edge; the expected RAM image is computed directly from the
// accepted source words with the CBD2 rule (coefficient = popcount of bits
// 0..1 minus popcount of bits 2..3 of each nibble).
module tb_cbd_seq;

  logic        clk, reset, start, abort;
  logic [2:0]  n_poly;
  logic        busy, done, err;
  logic        src_valid, src_ready;
  logic [31:0] src_data_1, src_data_2;
  logic        cbd_set, cbd_readin, cbd_ok_in, cbd_ok_out, cbd_readout;
  logic [31:0] cbd_din_1, cbd_din_2;
  logic [15:0] cbd_dout_1, cbd_dout_2;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata_1, mem_wdata_2;

  cbd_seq dut (
    .clk(clk), .reset(reset), .start(start), .n_poly(n_poly), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_data_1(src_data_1), .src_data_2(src_data_2),
    .cbd_set(cbd_set), .cbd_din_1(cbd_din_1), .cbd_din_2(cbd_din_2),
    .cbd_readin(cbd_readin), .cbd_ok_in(cbd_ok_in),
    .cbd_dout_1(cbd_dout_1), .cbd_dout_2(cbd_dout_2),
    .cbd_ok_out(cbd_ok_out), .cbd_readout(cbd_readout),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata_1(mem_wdata_1), .mem_wdata_2(mem_wdata_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] c1;
    logic [15:0] c2;
    int          avail;
  } cpair_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int flush_gen = 0;
  int seen_gen = 0;
  int src_valid_pct = 100;
  int ok_out_pct = 100;
  bit ok_in_hold_low = 1'b0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [31:0] src_log1[$];
  logic [31:0] src_log2[$];
  logic [8:0]  wr_addr[$];
  logic [15:0] wr_d1[$];
  logic [15:0] wr_d2[$];
  cpair_t      cq[$];

  function automatic logic [15:0] cbd2(input logic [31:0] w, input int k);
    logic [3:0] nib;
    int a, b;
    nib = w[4*k +: 4];
    a = int'(nib[0]) + int'(nib[1]);
    b = int'(nib[2]) + int'(nib[3]);
    return 16'(a - b);
  endfunction

  // Number of logged writes whose address is not the running pair index.
  function automatic int bad_addr_count();
    int bad = 0;
    for (int j = 0; j < wr_addr.size(); j++)
      if (wr_addr[j] !== 9'(j)) bad++;
    return bad;
  endfunction

  // Number of logged writes whose data differ from CBD2 of the source words.
  function automatic int bad_data_count();
    int bad = 0;
    for (int j = 0; j < wr_d1.size(); j++) begin
      if (j / 8 >= src_log1.size()) bad++;
      else if (wr_d1[j] !== cbd2(src_log1[j/8], j % 8) ||
               wr_d2[j] !== cbd2(src_log2[j/8], j % 8)) bad++;
    end
    return bad;
  endfunction

  // Upstream source, cbd model and write monitor. DUT handshake outputs
  // depend only on registers, so they are stable from here to the next rise.
  initial begin
    cpair_t e;
    src_valid = 1'b0; src_data_1 = '0; src_data_2 = '0;
    cbd_ok_in = 1'b0; cbd_ok_out = 1'b0; cbd_dout_1 = '0; cbd_dout_2 = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (flush_gen != seen_gen) begin
        seen_gen = flush_gen;
        src_log1.delete(); src_log2.delete();
        wr_addr.delete(); wr_d1.delete(); wr_d2.delete(); cq.delete();
      end
      src_valid  = ($urandom_range(0, 99) < src_valid_pct);
      src_data_1 = $urandom;
      src_data_2 = $urandom;
      if (src_valid && src_ready) begin
        src_log1.push_back(src_data_1);
        src_log2.push_back(src_data_2);
      end
      cbd_ok_in = !ok_in_hold_low;
      if (cbd_readin && cbd_ok_in)
        for (int k = 0; k < 8; k++) begin
          e.c1 = cbd2(cbd_din_1, k);
          e.c2 = cbd2(cbd_din_2, k);
          e.avail = cyc + 2;
          cq.push_back(e);
        end
      if (cq.size() > 0 && cq[0].avail <= cyc && $urandom_range(0, 99) < ok_out_pct) begin
        cbd_ok_out = 1'b1; cbd_dout_1 = cq[0].c1; cbd_dout_2 = cq[0].c2;
      end else begin
        cbd_ok_out = 1'b0; cbd_dout_1 = 16'($urandom); cbd_dout_2 = 16'($urandom);
      end
      if (cbd_readout && cbd_ok_out) void'(cq.pop_front());
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_d1.push_back(mem_wdata_1);
        wr_d2.push_back(mem_wdata_2);
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Flush model logs, pulse start for one cycle; returns in the ARM-cycle slot.
  task automatic start_cmd(input logic [2:0] n);
    flush_gen++;
    step();
    start = 1'b1; n_poly = n;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int i = 0;
    ok = 1'b0;
    while (!ok && i < limit) begin
      step();
      ok = done;
      i++;
    end
  endtask

  task automatic wait_writes(input int count, input int limit, output bit ok);
    int i = 0;
    ok = 1'b0;
    while (!ok && i < limit) begin
      step();
      ok = (wr_addr.size() >= count);
      i++;
    end
  endtask

  // Checks shared by every completed command: counts, addresses and data.
  task automatic check_image(input string tag, input int n);
    tests++;
    if (src_log1.size() !== 16 * n) begin
      fails++; $display("FAIL %s src_handshakes got %0d exp %0d", tag, src_log1.size(), 16 * n);
    end
    tests++;
    if (wr_addr.size() !== 128 * n) begin
      fails++; $display("FAIL %s write_count got %0d exp %0d", tag, wr_addr.size(), 128 * n);
    end
    tests++;
    if (bad_addr_count() !== 0) begin
      fails++; $display("FAIL %s addr_seq got %0d bad exp 0", tag, bad_addr_count());
    end
    tests++;
    if (bad_data_count() !== 0) begin
      fails++; $display("FAIL %s wdata got %0d bad exp 0", tag, bad_data_count());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; n_poly = 3'd0;
    #1;
    tests++;
    if ({busy, done, err, src_ready, cbd_set, cbd_readin, cbd_readout, mem_we,
         mem_addr, mem_wdata_1, mem_wdata_2, cbd_din_1, cbd_din_2} !== '0) begin
      fails++; $display("FAIL reset_outputs got nonzero exp all zero");
    end
    repeat (3) step();
    reset = 1'b1;
    step();
    tests++;
    if ({busy, src_ready, cbd_readout} !== 3'b000) begin
      fails++; $display("FAIL reset_idle got %b exp 000", {busy, src_ready, cbd_readout});
    end
  endtask

  task automatic test_single();
    bit ok;
    int dsnap;
    src_valid_pct = 100; ok_out_pct = 100;
    dsnap = done_cnt;
    start_cmd(3'd1);
    tests++;
    if ({busy, cbd_set} !== 2'b10) begin
      fails++; $display("FAIL single_arm got %b exp 10", {busy, cbd_set});
    end
    step();
    tests++;
    if ({busy, cbd_set} !== 2'b11) begin
      fails++; $display("FAIL single_run got %b exp 11", {busy, cbd_set});
    end
    wait_done(2000, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL single_done timeout got 0 exp 1");
    end
    tests++;
    if ({cbd_readout, cbd_set, busy} !== 3'b011) begin
      fails++; $display("FAIL single_done_state got %b exp 011", {cbd_readout, cbd_set, busy});
    end
    step();
    tests++;
    if ({busy, done, cbd_set} !== 3'b000) begin
      fails++; $display("FAIL single_after got %b exp 000", {busy, done, cbd_set});
    end
    tests++;
    if (done_cnt - dsnap !== 1) begin
      fails++; $display("FAIL single_done_pulses got %0d exp 1", done_cnt - dsnap);
    end
    check_image("single", 1);
  endtask

  task automatic test_multi();
    bit ok;
    int dsnap;
    src_valid_pct = 60; ok_out_pct = 50;
    dsnap = done_cnt;
    start_cmd(3'd4);
    repeat (5) step();
    start = 1'b1; n_poly = 3'd1;
    step();
    start = 1'b0;
    wait_done(20000, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL multi_done timeout got 0 exp 1");
    end
    step();
    tests++;
    if (done_cnt - dsnap !== 1) begin
      fails++; $display("FAIL multi_done_pulses got %0d exp 1", done_cnt - dsnap);
    end
    check_image("multi", 4);
  endtask

  task automatic test_illegal();
    logic [2:0] bad_n [3] = '{3'd0, 3'd5, 3'd7};
    int esnap;
    bit quiet;
    src_valid_pct = 100; ok_out_pct = 100;
    for (int i = 0; i < 3; i++) begin
      esnap = err_cnt;
      start_cmd(bad_n[i]);
      tests++;
      if ({err, busy} !== 2'b10) begin
        fails++; $display("FAIL illegal_err n=%0d got %b exp 10", bad_n[i], {err, busy});
      end
      quiet = 1'b1;
      repeat (5) begin
        step();
        if (busy || src_ready || mem_we || err) quiet = 1'b0;
      end
      tests++;
      if (!quiet) begin
        fails++; $display("FAIL illegal_quiet n=%0d got activity exp none", bad_n[i]);
      end
      tests++;
      if (err_cnt - esnap !== 1) begin
        fails++; $display("FAIL illegal_pulses n=%0d got %0d exp 1", bad_n[i], err_cnt - esnap);
      end
    end
  endtask

  task automatic test_abort();
    bit ok;
    int dsnap, wsnap;
    src_valid_pct = 100; ok_out_pct = 100;
    start_cmd(3'd2);
    wait_writes(40, 2000, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL abort_reach40 timeout got %0d exp 40", wr_addr.size());
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++;
    if ({busy, cbd_set, src_ready, cbd_readout, cbd_readin} !== 5'b00000) begin
      fails++; $display("FAIL abort_idle got %b exp 00000",
                        {busy, cbd_set, src_ready, cbd_readout, cbd_readin});
    end
    dsnap = done_cnt; wsnap = wr_addr.size();
    repeat (20) step();
    tests++;
    if (wr_addr.size() !== wsnap || done_cnt !== dsnap) begin
      fails++; $display("FAIL abort_silent got %0d writes %0d dones exp 0 0",
                        wr_addr.size() - wsnap, done_cnt - dsnap);
    end
    start_cmd(3'd1);
    wait_done(2000, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL abort_restart timeout got 0 exp 1");
    end
    step();
    check_image("abort_restart", 1);
  endtask

  task automatic test_reset_midrun();
    bit ok;
    int dsnap, wsnap;
    src_valid_pct = 80; ok_out_pct = 80;
    start_cmd(3'd2);
    wait_writes(30, 2000, ok);
    dsnap = done_cnt;
    reset = 1'b0;
    #1;
    tests++;
    if ({busy, done, err, src_ready, cbd_set, cbd_readin, cbd_readout, mem_we,
         mem_addr, mem_wdata_1, mem_wdata_2} !== '0) begin
      fails++; $display("FAIL midrun_reset got nonzero exp all zero");
    end
    step();
    reset = 1'b1;
    wsnap = wr_addr.size();
    repeat (10) step();
    tests++;
    if (done_cnt !== dsnap || wr_addr.size() !== wsnap || busy !== 1'b0) begin
      fails++; $display("FAIL midrun_quiet got %0d dones %0d writes busy=%b exp 0 0 0",
                        done_cnt - dsnap, wr_addr.size() - wsnap, busy);
    end
    start_cmd(3'd1);
    wait_done(4000, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL midrun_restart timeout got 0 exp 1");
    end
    step();
    check_image("midrun_restart", 1);
  endtask

  task automatic test_ok_in_stall();
    bit ok;
    int i;
    logic [31:0] d1, d2;
    src_valid_pct = 100; ok_out_pct = 100;
    ok_in_hold_low = 1'b1;
    start_cmd(3'd1);
    i = 0;
    while (!cbd_readin && i < 20) begin
      step();
      i++;
    end
    tests++;
    if (cbd_readin !== 1'b1) begin
      fails++; $display("FAIL stall_fill got %b exp 1", cbd_readin);
    end
    d1 = cbd_din_1; d2 = cbd_din_2;
    for (int c = 0; c < 20; c++) begin
      step();
      tests++;
      if ({src_ready, cbd_readin} !== 2'b01 || cbd_din_1 !== d1 || cbd_din_2 !== d2) begin
        fails++; $display("FAIL stall_hold cycle %0d got ready=%b readin=%b din=%h_%h exp 0 1 %h_%h",
                          c, src_ready, cbd_readin, cbd_din_1, cbd_din_2, d1, d2);
      end
    end
    ok_in_hold_low = 1'b0;
    step();
    step();
    tests++;
    if (cbd_readin !== 1'b0) begin
      fails++; $display("FAIL stall_release got %b exp 0", cbd_readin);
    end
    wait_done(2000, ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL stall_done timeout got 0 exp 1");
    end
    step();
    check_image("stall", 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_illegal();
    test_abort();
    test_reset_midrun();
    test_ok_in_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cbd_seq.md
Name: cbd_seq

Overview:
- Sequencer for the dual-lane CBD sampler (eta=2).
- Takes a command to sample 1..KMAX polynomials, pulls 32-bit word pairs from the upstream PRF/XOF byte-stream buffer and feeds them into cbd.
- Collects cbd coefficient pairs and writes them to polynomial RAM at sequential addresses.
- Sits between the XOF buffer, the cbd instance and the poly RAM write port in the keygen/encaps datapath.

Parameters:
- N, 256, coefficients per polynomial.
- COEF_PER_WORD, 8, coefficients per 32-bit input word (32/(2*eta)).
- KMAX, 4, maximum polynomials per command.
- IN_PER_POLY, 16, word pairs per polynomial (N/(2*COEF_PER_WORD)).
- OUT_PER_POLY, 128, coefficient pairs per polynomial (N/2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command strobe, sampled in IDLE only.
- n_poly  in  3  polynomials to sample; legal range 1..KMAX.
- abort  in  1  cancel current command.
- busy  out  1  high from accepted start until DONE exits.
- done  out  1  one-cycle pulse after last RAM write.
- err  out  1  one-cycle pulse on illegal n_poly at start.
- src_valid  in  1  upstream word pair valid.
- src_ready  out  1  sequencer accepts word pair.
- src_data_1  in  32  upstream word, lane 1.
- src_data_2  in  32  upstream word, lane 2.
- cbd_set  out  1  cbd enable.
- cbd_din_1  out  32  cbd input word, lane 1.
- cbd_din_2  out  32  cbd input word, lane 2.
- cbd_readin  out  1  input pair valid to cbd.
- cbd_ok_in  in  1  cbd can accept input.
- cbd_dout_1  in  16  signed coefficient, lane 1.
- cbd_dout_2  in  16  signed coefficient, lane 2.
- cbd_ok_out  in  1  cbd output pair valid.
- cbd_readout  out  1  sequencer consumes output pair.
- mem_we  out  1  RAM write strobe.
- mem_addr  out  9  {poly_idx[1:0], pair_idx[6:0]}.
- mem_wdata_1  out  16  coefficient 2*pair_idx.
- mem_wdata_2  out  16  coefficient 2*pair_idx+1.

Behaviour:

Reset values:
- Reset low clears all registers.
- All outputs are 0: state=IDLE, counters=0, in_buf empty, cbd_set=0.

States:
- IDLE -> ARM on start with 1<=n_poly<=KMAX. Latch total_in=16*n_poly and total_out=128*n_poly.
- IDLE, start with illegal n_poly: stay in IDLE, err=1 for one cycle.
- ARM (1 cycle): cbd_set<=1 -> RUN.
- RUN -> DONE when out_cnt==total_out and the final mem_we has been issued.
- DONE (1 cycle): done=1, cbd_set<=0 -> IDLE.
- busy=1 in ARM, RUN and DONE.

Input channel (RUN only):
- One-entry buffer in_buf.
- src_ready = RUN & !in_buf_valid & in_cnt<total_in.
- On src_valid&src_ready: latch both words, set in_buf_valid, in_cnt++.
- cbd_din_1/2 are driven from in_buf. cbd_readin = in_buf_valid.
- Transfer completes on cbd_readin&cbd_ok_in; in_buf_valid clears the same edge.
- Max throughput: one pair per 2 cycles.

Output channel (RUN only):
- cbd_readout = RUN & out_cnt<total_out.
- On cbd_readout&cbd_ok_out: register dout_1/2, issue mem_we=1 on the next cycle with mem_addr=out_cnt[8:0], then out_cnt++.
- Latency from output consume to RAM write: 1 cycle.
- mem_we is otherwise 0.
- Address wraps naturally across polynomials: 127 -> 128 = poly 1, pair 0.

Boundaries:
- Once in_cnt==total_in, src_ready stays 0; excess upstream data is left untouched.
- Once out_cnt==total_out, cbd_readout stays 0; stray cbd output is not consumed.
- Both channels may transfer in the same cycle.
- start while busy is ignored.
- abort in ARM or RUN: next edge goes to IDLE, cbd_set=0, in_buf cleared, counters cleared, no done. A mem_we already registered still completes that cycle.
- Reset asserted mid-run: immediate clear, no done, no further writes.

Decomposition:
- Shared package kyber_pkg holds N, ETA, COEF_PER_WORD, KMAX, IN_PER_POLY, OUT_PER_POLY and the state encoding (IDLE, ARM, RUN, DONE).
- No sub-module; the cbd instance stays outside, wired by the parent.

Test Plan:
- n_poly=1, upstream always valid, cbd model with ok_in=1 and ok_out 2 cycles after input -> exactly 16 src handshakes, 128 mem_we with addr 0..127 in order, data matching the reference CBD2 vectors, single done pulse, busy falls the cycle after done.
- n_poly=4 with random src_valid and cbd_ok_out stalls -> 512 writes, addr 0..511 contiguous, 64 src handshakes, no lost or duplicated pairs.
- start with n_poly=0, then with n_poly=5 -> err pulse each time, busy stays 0, no src_ready, no mem_we.
- abort asserted after 40 mem writes with n_poly=2 -> IDLE next cycle, cbd_set=0, no done; a new start with n_poly=1 writes from addr 0.
- Reset pulled low in RUN for 1 cycle -> all outputs 0 asynchronously; the restarted command completes normally.
- cbd_ok_in held low for 20 cycles with in_buf full -> src_ready=0 and cbd_readin=1 held throughout, din stable; the transfer completes when ok_in rises.
